stepper_phase_driver: RTL and testbench
=======================================

// Module: stepper_phase_driver
// PURPOSE
//  Downstream stage of control_movimiento: one instance per axis (theta, phi) turns the
//  pos/neg motion commands into a stepper coil sequence at a fixed step rate.
//  Tracks the axis position in steps and returns it as the axis "actual" angle word,
//  closing the loop back into control_movimiento (theta_actual / phi_actual).
// PARAMETERS
//  STEP_DIV  50000  clock cycles per step period (>=2)
//  POS_W     16     width of position counter
//  POS_MAX   360    upper position limit in steps (half-steps if HALF_STEP_EN); lower limit 0
// PORTS
//  clk       in   1      system clock; single clock domain
//  rst       in   1      synchronous reset, active-high
//  cmd_pos   in   1      move positive (from s_out_*_pos)
//  cmd_neg   in   1      move negative (from s_out_*_neg)
//  coil      out  4      coil drive pattern A,B,C,D (bit0=A)
//  position  out  POS_W  current position in steps
//  busy      out  1      1 in RUN_POS, RUN_NEG or DWELL
//  at_limit  out  1      1 when a requested step is blocked by 0 or POS_MAX
// BEHAVIOUR
//  Reset: coil=4'b0000, position=0, phase=0, busy=0, at_limit=0, state=IDLE, tick cnt=0.
//  Reset mid-operation: same values on next edge; any partial step period is discarded.
//  Command decode per cycle: pos only -> P; neg only -> N; both or neither -> STOP.
//  FSM: IDLE, RUN_POS, RUN_NEG, DWELL.
//   IDLE: P->RUN_POS, N->RUN_NEG, STOP->IDLE. Tick counter cleared on every entry to RUN_*.
//   RUN_POS: STOP->IDLE (counter cleared, no partial step); N->DWELL; P->stay.
//   RUN_NEG: mirror of RUN_POS.
//   DWELL: counts one full STEP_DIV period with coils unchanged, then -> RUN_* per current
//     command (STOP during dwell -> IDLE immediately). Direction reversal never steps sooner.
//  Step timing: tick counter counts 0..STEP_DIV-1 while in RUN_*; on count STEP_DIV-1 a step
//   is issued and counter wraps to 0. First coil change occurs STEP_DIV cycles after the
//   first cycle the FSM is in RUN_*; subsequent steps every STEP_DIV cycles.
//  Step issue (RUN_POS): if position<POS_MAX: phase=phase+1 (wraps max->0), position+=1,
//   at_limit=0; else no change, at_limit=1, state stays RUN_POS. RUN_NEG mirrors with
//   phase-1 (0 wraps to max) and position floor 0.
//  at_limit clears on the next successful step or on entering IDLE.
//  coil is registered from phase; stays at 0 after reset until first step, then holds last
//   pattern in IDLE/DWELL (holding torque). position never wraps; saturates at 0 / POS_MAX.
//  busy registered, equals (state!=IDLE) one cycle after state update.
// CONFIGURATION
//  HALF_STEP_EN defined: 8-entry phase table 0001,0011,0010,0110,0100,1100,1000,1001;
//   phase is 3 bits; position counts half-steps.
//  Not defined: 4-entry wave table 0001,0010,0100,1000; phase is 2 bits; full steps.
//  All FSM/timing rules identical in both builds.
// STRUCTURE
//  motor_pkg: FSM state enum, coil table constants (full and half), command decode enum.
//  Sub-module step_tick_gen: STEP_DIV divider with synchronous clear input and one-cycle
//   tick output; FSM, phase/position registers and coil lookup stay in this module.
// TESTING (bench uses STEP_DIV=4, POS_MAX=5, macro off unless stated)
//  1 rst=1 two cycles, release -> coil=0000, position=0, busy=0, at_limit=0.
//  2 cmd_pos=1 held 12 cycles -> coil 0001,0010,0100 at cycles 4,8,12 after RUN_POS entry;
//    position 1,2,3.
//  3 From position 3 hold cmd_pos -> position 4,5 then at_limit=1, coil frozen, busy=1.
//  4 In RUN_POS switch to cmd_neg -> DWELL 4 cycles no coil change, then step back:
//    phase-1, position-1, at_limit=0.
//  5 cmd_pos=cmd_neg=1 mid-period, or drop both after 2 cycles -> IDLE, no step,
//    position unchanged, coil held.
//  6 HALF_STEP_EN build, cmd_neg from reset -> at_limit=1 at first tick; then cmd_pos 9
//    steps (POS_MAX=9) -> table walks 0001..1001 then wraps to 0001.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared FSM/command types and coil sequence tables for stepper_phase_driver.
// Build option: define HALF_STEP_EN to select the 8-entry half-step table.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_POS = 2'd1,
    ST_RUN_NEG = 2'd2,
    ST_DWELL   = 2'd3
  } motor_state_e;

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_P    = 2'd1,
    CMD_N    = 2'd2
  } motor_cmd_e;

  // Tables are packed with entry 0 in the least significant nibble.
  localparam logic [15:0] COIL_FULL = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [31:0] COIL_HALF = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                       4'b0110, 4'b0010, 4'b0011, 4'b0001};

`ifdef HALF_STEP_EN
  localparam bit HALF_STEP = 1'b1;
  localparam int PHASE_W   = 3;
`else
  localparam bit HALF_STEP = 1'b0;
  localparam int PHASE_W   = 2;
`endif

  function automatic motor_cmd_e decode_cmd(input logic pos, input logic neg);
    motor_cmd_e c;
    case ({pos, neg})
      2'b10:   c = CMD_P;
      2'b01:   c = CMD_N;
      default: c = CMD_STOP;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] coil_of(input logic [PHASE_W-1:0] ph);
    logic [3:0] pattern;
    if (HALF_STEP) begin
      pattern = COIL_HALF[int'(ph) * 4 +: 4];
    end else begin
      pattern = COIL_FULL[int'(ph[1:0]) * 4 +: 4];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-period divider: counts 0..STEP_DIV-1 while enabled and pulses tick
// on the last count; clr restarts the period so no partial step survives.
module step_tick_gen #(
  parameter int STEP_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Period counter with synchronous clear and wrap on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || !en) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/stepper_phase_driver.sv
// Per-axis stepper driver: turns pos/neg commands into a coil sequence and
// tracks position in steps. Build option HALF_STEP_EN selects half-stepping.
module stepper_phase_driver
  import motor_pkg::*;
#(
  parameter int STEP_DIV = 50000,
  parameter int POS_W    = 16,
  parameter int POS_MAX  = 360
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_pos,
  input  logic             cmd_neg,
  output logic [3:0]       coil,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             at_limit
);

  localparam logic [POS_W-1:0] POS_LIMIT = POS_W'(POS_MAX);

  motor_state_e       state_r;
  motor_state_e       state_next_s;
  motor_cmd_e         cmd_s;
  logic               tick_s;
  logic               step_s;
  logic               tick_clr_s;
  logic               tick_en_s;
  logic [PHASE_W-1:0] phase_r;
  logic [3:0]         coil_r;
  logic [POS_W-1:0]   position_r;
  logic               busy_r;
  logic               at_limit_r;

  assign cmd_s      = decode_cmd(cmd_pos, cmd_neg);
  // Any state change (entry to RUN_* or DWELL) restarts the step period.
  assign tick_clr_s = (state_next_s != state_r);
  assign tick_en_s  = (state_r != ST_IDLE);

  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr_s),
    .en   (tick_en_s),
    .tick (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a step is only issued while holding the same direction.
  always_comb begin
    state_next_s = state_r;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        case (cmd_s)
          CMD_P:   state_next_s = ST_RUN_POS;
          CMD_N:   state_next_s = ST_RUN_NEG;
          default: state_next_s = ST_IDLE;
        endcase
      end
      ST_RUN_POS: begin
        case (cmd_s)
          CMD_P:   step_s       = tick_s;
          CMD_N:   state_next_s = ST_DWELL;
          default: state_next_s = ST_IDLE;
        endcase
      end
      ST_RUN_NEG: begin
        case (cmd_s)
          CMD_N:   step_s       = tick_s;
          CMD_P:   state_next_s = ST_DWELL;
          default: state_next_s = ST_IDLE;
        endcase
      end
      ST_DWELL: begin
        case (cmd_s)
          CMD_P: begin
            if (tick_s) begin
              state_next_s = ST_RUN_POS;
            end else begin
              state_next_s = ST_DWELL;
            end
          end
          CMD_N: begin
            if (tick_s) begin
              state_next_s = ST_RUN_NEG;
            end else begin
              state_next_s = ST_DWELL;
            end
          end
          default: state_next_s = ST_IDLE;
        endcase
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Phase, position, coil and flag registers. phase counts steps taken, and
  // the coil shows table entry phase-1, so the first step energises entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r    <= {PHASE_W{1'b0}};
      position_r <= {POS_W{1'b0}};
      coil_r     <= 4'b0000;
      busy_r     <= 1'b0;
      at_limit_r <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE);
      if (step_s && (state_r == ST_RUN_POS)) begin
        if (position_r < POS_LIMIT) begin
          phase_r    <= phase_r + PHASE_W'(1);
          position_r <= position_r + POS_W'(1);
          coil_r     <= coil_of(phase_r);
          at_limit_r <= 1'b0;
        end else begin
          at_limit_r <= 1'b1;
        end
      end else if (step_s && (state_r == ST_RUN_NEG)) begin
        if (position_r != {POS_W{1'b0}}) begin
          phase_r    <= phase_r - PHASE_W'(1);
          position_r <= position_r - POS_W'(1);
          coil_r     <= coil_of(PHASE_W'(phase_r - PHASE_W'(2)));
          at_limit_r <= 1'b0;
        end else begin
          at_limit_r <= 1'b1;
        end
      end else if (state_next_s == ST_IDLE) begin
        at_limit_r <= 1'b0;
      end
    end
  end

  assign coil     = coil_r;
  assign position = position_r;
  assign busy     = busy_r;
  assign at_limit = at_limit_r;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Self-checking bench for stepper_phase_driver: directed scenarios plus random
// command runs against a cycle-level behavioural model (HALF_STEP_EN aware).
module tb_stepper_phase_driver;

  localparam int STEP_DIV = 4;
  localparam int POS_W    = 16;
`ifdef HALF_STEP_EN
  localparam int POS_MAX  = 9;
  localparam int NPH      = 8;
`else
  localparam int POS_MAX  = 5;
  localparam int NPH      = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_pos;
  logic             cmd_neg;
  logic [3:0]       coil;
  logic [POS_W-1:0] position;
  logic             busy;
  logic             at_limit;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] full_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] half_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0100, 4'b1100, 4'b1000, 4'b1001};

  // Reference state: mode 0 idle, 1 run+, 2 run-, 3 dwell; m_net = net steps taken.
  int         m_mode, m_timer, m_pos, m_net;
  logic [3:0] m_coil;
  logic       m_lim, m_busy;

  stepper_phase_driver #(.STEP_DIV(STEP_DIV), .POS_W(POS_W), .POS_MAX(POS_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_pos  (cmd_pos),
    .cmd_neg  (cmd_neg),
    .coil     (coil),
    .position (position),
    .busy     (busy),
    .at_limit (at_limit)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_coil(input int k);
    int m;
    m = ((k % NPH) + NPH) % NPH;
    return (NPH == 8) ? half_tbl[m] : full_tbl[m % 4];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_timer = 0; m_pos = 0; m_net = 0;
    m_coil = 4'b0000; m_lim = 1'b0; m_busy = 1'b0;
  endtask

  // One clock edge of the intended behaviour, given the command held that cycle.
  task automatic model_edge(input logic p, input logic n);
    int dir, d, target;
    dir = (p && !n) ? 1 : ((n && !p) ? -1 : 0);
    m_busy = (m_mode != 0);
    case (m_mode)
      0: begin
        if (dir != 0) begin
          m_mode = (dir > 0) ? 1 : 2;
          m_timer = 0;
        end
      end
      1, 2: begin
        d = (m_mode == 1) ? 1 : -1;
        if (dir == 0) begin
          m_mode = 0; m_lim = 1'b0;
        end else if (dir != d) begin
          m_mode = 3; m_timer = 0;
        end else if (m_timer == STEP_DIV - 1) begin
          m_timer = 0;
          target = m_pos + d;
          if (target >= 0 && target <= POS_MAX) begin
            m_pos = target; m_net += d; m_coil = ref_coil(m_net - 1); m_lim = 1'b0;
          end else begin
            m_lim = 1'b1;
          end
        end else begin
          m_timer++;
        end
      end
      default: begin
        if (dir == 0) begin
          m_mode = 0; m_lim = 1'b0;
        end else if (m_timer == STEP_DIV - 1) begin
          m_mode = (dir > 0) ? 1 : 2; m_timer = 0;
        end else begin
          m_timer++;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic p, input logic n);
    cmd_pos = p;
    cmd_neg = n;
    @(posedge clk);
    model_edge(p, n);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_pos = 1'b0; cmd_neg = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (coil !== 4'b0000 || position !== '0 || busy !== 1'b0 || at_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got coil=%b pos=%0d busy=%b lim=%b, want 0000/0/0/0", coil, position, busy, at_limit);
    end
    cycle(1'b0, 1'b0);
    n_checks++;
    if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
      n_fail++;
      $display("FAIL reset_idle: got %b/%0d/%b/%b want %b/%0d/%b/%b", coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
    end
  endtask

  task automatic test_pos_run();
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, 1'b0);
      n_checks++;
      if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
        n_fail++;
        $display("FAIL pos_run[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
      end
    end
    n_checks++;
    if (position !== POS_W'(3) || coil !== ref_coil(2)) begin
      n_fail++;
      $display("FAIL pos_run_end: got pos=%0d coil=%b want pos=3 coil=%b", position, coil, ref_coil(2));
    end
  endtask

  task automatic test_limit();
    for (int i = 0; i < 100 && !m_lim; i++) begin
      cycle(1'b1, 1'b0);
      n_checks++;
      if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
        n_fail++;
        $display("FAIL limit[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
      end
    end
    n_checks++;
    if (position !== POS_W'(POS_MAX) || at_limit !== 1'b1 || busy !== 1'b1 || coil !== ref_coil(POS_MAX - 1)) begin
      n_fail++;
      $display("FAIL limit_end: got pos=%0d lim=%b busy=%b coil=%b want pos=%0d lim=1 busy=1 coil=%b", position, at_limit, busy, coil, POS_MAX, ref_coil(POS_MAX - 1));
    end
  endtask

  task automatic test_reverse();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1);
      n_checks++;
      if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
        n_fail++;
        $display("FAIL reverse[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
      end
    end
    n_checks++;
    if (position !== POS_W'(POS_MAX - 1) || at_limit !== 1'b0 || coil !== ref_coil(POS_MAX - 2)) begin
      n_fail++;
      $display("FAIL reverse_end: got pos=%0d lim=%b coil=%b want pos=%0d lim=0 coil=%b", position, at_limit, coil, POS_MAX - 1, ref_coil(POS_MAX - 2));
    end
  endtask

  task automatic test_stop();
    int   held_pos;
    logic p_seq [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic n_seq [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cycle(1'b0, 1'b0);
    held_pos = m_pos;
    for (int i = 0; i < 14; i++) begin
      cycle(p_seq[i], n_seq[i]);
      n_checks++;
      if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
        n_fail++;
        $display("FAIL stop[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
      end
    end
    n_checks++;
    if (position !== POS_W'(held_pos) || busy !== 1'b0 || coil !== ref_coil(POS_MAX - 2)) begin
      n_fail++;
      $display("FAIL stop_end: got pos=%0d busy=%b coil=%b want pos=%0d busy=0 coil=%b", position, busy, coil, held_pos, ref_coil(POS_MAX - 2));
    end
  endtask

  task automatic test_random();
    logic p, n;
    int   len;
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end
      case ($urandom_range(0, 5))
        0:       begin p = 1'b0; n = 1'b0; end
        1:       begin p = 1'b1; n = 1'b1; end
        2, 3:    begin p = 1'b1; n = 1'b0; end
        default: begin p = 1'b0; n = 1'b1; end
      endcase
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        cycle(p, n);
        n_checks++;
        if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", s, i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
        end
      end
    end
  endtask

`ifdef HALF_STEP_EN
  task automatic test_half_step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
    end
    n_checks++;
    if (at_limit !== 1'b1 || position !== '0 || coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL half_floor: got lim=%b pos=%0d coil=%b want lim=1 pos=0 coil=0000", at_limit, position, coil);
    end
    for (int i = 0; i < 200 && m_pos < POS_MAX; i++) begin
      cycle(1'b1, 1'b0);
      n_checks++;
      if ({coil, position, busy, at_limit} !== {m_coil, POS_W'(m_pos), m_busy, m_lim}) begin
        n_fail++;
        $display("FAIL half_walk[%0d]: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, coil, position, busy, at_limit, m_coil, m_pos, m_busy, m_lim);
      end
    end
    n_checks++;
    if (coil !== 4'b0001 || position !== POS_W'(9) || at_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL half_wrap: got coil=%b pos=%0d lim=%b want coil=0001 pos=9 lim=0", coil, position, at_limit);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_pos = 1'b0; cmd_neg = 1'b0;
    model_reset();
    test_reset();
    test_pos_run();
    test_limit();
    test_reverse();
    test_stop();
`ifdef HALF_STEP_EN
    test_half_step();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
